// File: rtl/pwm_capture_if.sv
// Bundles the PWM input and the measurement result bus of pwm_capture.
// master = the capture block, slave = whatever consumes the results.
interface pwm_capture_if #(
  parameter int CTR_WIDTH  = 16,
  parameter int DUTY_WIDTH = 10
);
  logic                  pwm_in;
  logic [CTR_WIDTH-1:0]  period;
  logic [CTR_WIDTH-1:0]  high_time;
  logic [DUTY_WIDTH-1:0] duty;
  logic                  valid;
  logic                  stuck;
  logic                  busy;

  modport master (
    input  pwm_in,
    output period, high_time, duty, valid, stuck, busy
  );

  modport slave (
    output pwm_in,
    input  period, high_time, duty, valid, stuck, busy
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures period/high time of an asynchronous PWM input between rising edges and
// derives duty = floor(high * 2**DUTY_WIDTH / period) with a bit-serial restoring divider.
module pwm_capture #(
  parameter int CTR_WIDTH  = 16,
  parameter int DUTY_WIDTH = 10
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.master cap
);

  localparam int IT_W = $clog2(DUTY_WIDTH + 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);
  localparam logic [IT_W-1:0]      IT_LAST  = IT_W'(DUTY_WIDTH);

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  sync1_q, sync1_d;
  logic                  pwm_s_q, pwm_s_d;
  logic                  pwm_dly_q, pwm_dly_d;
  logic [CTR_WIDTH-1:0]  period_ctr_q, period_ctr_d;
  logic [CTR_WIDTH-1:0]  high_ctr_q, high_ctr_d;
  logic [CTR_WIDTH-1:0]  p_q, p_d;
  logic [CTR_WIDTH-1:0]  h_q, h_d;
  logic [CTR_WIDTH-1:0]  rem_q, rem_d;
  logic [DUTY_WIDTH-1:0] quo_q, quo_d;
  logic [IT_W-1:0]       it_q, it_d;
  logic [CTR_WIDTH-1:0]  period_q, period_d;
  logic [CTR_WIDTH-1:0]  high_time_q, high_time_d;
  logic [DUTY_WIDTH-1:0] duty_q, duty_d;
  logic                  valid_q, valid_d;
  logic                  stuck_q, stuck_d;

  logic                  rise;
  logic                  timeout_hit;
  logic                  capture;
  logic                  div_step;
  logic                  div_done;
  logic                  to_fire;
  logic                  busy;
  logic [CTR_WIDTH:0]    rem_shift;
  logic [CTR_WIDTH-1:0]  rem_sub;
  logic                  rem_ge;

  assign rise = pwm_s_q & ~pwm_dly_q;
  // Fires only on the step into saturation, so a held input yields one pulse.
  assign timeout_hit = ~rise & (period_ctr_q == (CTR_MAX - CTR_ONE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARM: begin
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise)             state_d = DIVIDE;
        else if (timeout_hit) state_d = ARM;
      end
      DIVIDE: begin
        if (it_q == IT_LAST) state_d = MEASURE;
      end
      default: state_d = ARM;
    endcase
  end

  // FSM outputs
  always_comb begin
    capture  = 1'b0;
    div_step = 1'b0;
    div_done = 1'b0;
    to_fire  = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ARM: begin
        to_fire = timeout_hit;
      end
      MEASURE: begin
        capture = rise;
        to_fire = timeout_hit;
      end
      DIVIDE: begin
        busy     = 1'b1;
        div_step = (it_q != IT_LAST);
        div_done = (it_q == IT_LAST);
      end
      default: ;
    endcase
  end

  // Since h < p, the partial remainder always stays below p and fits CTR_WIDTH bits.
  always_comb begin
    rem_shift = {rem_q, 1'b0};
    rem_ge    = (rem_shift >= {1'b0, p_q});
    rem_sub   = rem_shift[CTR_WIDTH-1:0] - p_q;
  end

  always_comb begin
    sync1_d     = cap.pwm_in;
    pwm_s_d     = sync1_q;
    pwm_dly_d   = pwm_s_q;

    period_ctr_d = period_ctr_q;
    high_ctr_d   = high_ctr_q;
    if (rise) begin
      period_ctr_d = CTR_ONE;
      high_ctr_d   = CTR_ONE;
    end else begin
      if (period_ctr_q != CTR_MAX) period_ctr_d = period_ctr_q + CTR_ONE;
      if (pwm_s_q && (high_ctr_q != CTR_MAX)) high_ctr_d = high_ctr_q + CTR_ONE;
    end

    p_d         = p_q;
    h_d         = h_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    it_d        = it_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    duty_d      = duty_q;
    stuck_d     = stuck_q;
    valid_d     = 1'b0;

    if (capture) begin
      p_d   = period_ctr_q;
      h_d   = high_ctr_q;
      rem_d = high_ctr_q;
      quo_d = '0;
      it_d  = '0;
    end

    if (div_step) begin
      it_d  = it_q + 1'b1;
      rem_d = rem_ge ? rem_sub : rem_shift[CTR_WIDTH-1:0];
      quo_d = {quo_q[DUTY_WIDTH-2:0], rem_ge};
    end

    if (div_done) begin
      period_d    = p_q;
      high_time_d = h_q;
      duty_d      = quo_q;
      stuck_d     = 1'b0;
      valid_d     = 1'b1;
    end

    if (to_fire) begin
      period_d    = '0;
      high_time_d = '0;
      duty_d      = pwm_s_q ? '1 : '0;
      stuck_d     = 1'b1;
      valid_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      pwm_s_q      <= 1'b0;
      pwm_dly_q    <= 1'b0;
      period_ctr_q <= '0;
      high_ctr_q   <= '0;
      p_q          <= '0;
      h_q          <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      it_q         <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      duty_q       <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      pwm_s_q      <= pwm_s_d;
      pwm_dly_q    <= pwm_dly_d;
      period_ctr_q <= period_ctr_d;
      high_ctr_q   <= high_ctr_d;
      p_q          <= p_d;
      h_q          <= h_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      it_q         <= it_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      duty_q       <= duty_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
    end
  end

  assign cap.period    = period_q;
  assign cap.high_time = high_time_q;
  assign cap.duty      = duty_q;
  assign cap.valid     = valid_q;
  assign cap.stuck     = stuck_q;
  assign cap.busy      = busy;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: an event-level reference model is compared
// against the DUT every cycle, plus literal expectations for the key scenarios.
module tb_pwm_capture;
  localparam int CW   = 8;
  localparam int DW   = 10;
  localparam int MAXV = (1 << CW) - 1;
  localparam int FULL = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_capture_if #(.CTR_WIDTH(CW), .DUTY_WIDTH(DW)) bus ();

  pwm_capture #(.CTR_WIDTH(CW), .DUTY_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .cap (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: time since last rise, high samples, capture/done schedule.
  int cyc = 0;
  bit m_s1, m_s, m_sd;
  int m_since, m_hi, m_phase, m_done, m_cap_cyc, m_p, m_h;
  int m_period, m_high, m_duty;
  bit m_stuck, m_valid;

  always @(posedge clk) begin
    bit rise;
    int os, oh;
    cyc++;
    if (rst) begin
      m_s1 = 0; m_s = 0; m_sd = 0;
      m_since = 0; m_hi = 0; m_phase = 0; m_done = -1;
      m_period = 0; m_high = 0; m_duty = 0; m_stuck = 0; m_valid = 0;
    end else begin
      rise = m_s && !m_sd;
      os = m_since;
      oh = m_hi;
      m_valid = 0;
      if (m_phase == 2) begin
        if (cyc == m_done) begin
          m_period = m_p; m_high = m_h; m_duty = (m_h << DW) / m_p;
          m_stuck = 0; m_valid = 1; m_phase = 1;
        end
      end else if (rise) begin
        if (m_phase == 0) m_phase = 1;
        else begin
          m_p = os; m_h = oh; m_cap_cyc = cyc; m_done = cyc + DW + 1; m_phase = 2;
        end
      end else if (os == MAXV - 1) begin
        m_stuck = 1; m_duty = m_s ? FULL : 0; m_period = 0; m_high = 0;
        m_valid = 1; m_phase = 0;
      end
      m_since = rise ? 1 : (os < MAXV ? os + 1 : MAXV);
      m_hi    = rise ? 1 : ((m_s && oh < MAXV) ? oh + 1 : oh);
      m_sd = m_s; m_s = m_s1; m_s1 = bus.pwm_in;
    end
  end

  bit cmp_on = 0;
  bit t4_on = 0;
  int n_valid = 0, n_stuck_valid = 0, t4_cnt = 0;
  int last_valid_cyc = 0, lat = 0, rel_cyc = 0;

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("valid", bus.valid, m_valid);
      chk("busy", bus.busy, m_phase == 2);
      chk("stuck", bus.stuck, m_stuck);
      chk("period", bus.period, m_period);
      chk("high_time", bus.high_time, m_high);
      chk("duty", bus.duty, m_duty);
      if (bus.valid === 1'b1) begin
        n_valid++;
        last_valid_cyc = cyc;
        lat = cyc - m_cap_cyc;
        if (bus.stuck === 1'b1) n_stuck_valid++;
        if (t4_on) begin
          t4_cnt++;
          chk("t4_period", bus.period, 5);
          chk("t4_duty", bus.duty, 409);
        end
      end
    end
  end

  task automatic pwm(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < per; i++) begin
        @(negedge clk);
        bus.pwm_in = (i < hi);
      end
  endtask

  task automatic hold(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.pwm_in = v;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel_cyc = cyc;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, w;
    bus.pwm_in = 1'b0;
    do_reset();
    cmp_on = 1;
    chk("rst_valid", bus.valid, 0);
    chk("rst_period", bus.period, 0);
    chk("rst_duty", bus.duty, 0);
    chk("rst_stuck", bus.stuck, 0);

    // Period 100, high 25: first rise arms only
    pwm(100, 25, 3);
    chk("t1_nvalid", n_valid, 2);
    chk("t1_period", bus.period, 100);
    chk("t1_high", bus.high_time, 25);
    chk("t1_duty", bus.duty, 256);
    chk("t1_latency", lat, 11);
    chk("t1_model_duty", m_duty, 256);

    pwm(100, 99, 3);
    chk("t2_duty_hi", bus.duty, 1013);
    pwm(100, 1, 3);
    chk("t2_duty_lo", bus.duty, 10);
    chk("t2_high", bus.high_time, 1);

    // Stuck high after lock, then recovery
    v0 = n_stuck_valid;
    hold(1'b1, 400);
    chk("t3_stuck_pulses", n_stuck_valid - v0, 1);
    chk("t3_stuck", bus.stuck, 1);
    chk("t3_duty", bus.duty, FULL);
    chk("t3_period", bus.period, 0);
    chk("t3_high", bus.high_time, 0);
    pwm(40, 10, 3);
    chk("t3_unstuck", bus.stuck, 0);
    chk("t3_rec_duty", bus.duty, 256);
    chk("t3_rec_period", bus.period, 40);

    // Period shorter than the divide: intermediate rises are dropped
    pwm(5, 2, 4);
    t4_on = 1;
    pwm(5, 2, 26);
    t4_on = 0;
    chk("t4_some_valids", t4_cnt >= 5, 1);

    // Reset in the middle of a divide
    pwm(100, 25, 2);
    @(negedge clk);
    bus.pwm_in = 1'b1;
    w = 0;
    while (bus.busy !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("t5_busy_seen", bus.busy, 1);
    rst = 1'b1;
    bus.pwm_in = 1'b0;
    v0 = n_valid;
    @(negedge clk);
    chk("t5_valid0", bus.valid, 0);
    chk("t5_busy0", bus.busy, 0);
    chk("t5_duty0", bus.duty, 0);
    chk("t5_period0", bus.period, 0);
    rst = 1'b0;
    hold(1'b0, 10);
    pwm(100, 25, 1);
    chk("t5_no_valid_first", n_valid - v0, 0);
    pwm(100, 25, 1);
    chk("t5_valid_second", n_valid - v0, 1);
    chk("t5_duty", bus.duty, 256);

    // Input low from reset
    do_reset();
    v0 = n_stuck_valid;
    hold(1'b0, 300);
    chk("t6_stuck_pulses", n_stuck_valid - v0, 1);
    chk("t6_timeout_cycle", last_valid_cyc - rel_cyc, 255);
    chk("t6_stuck", bus.stuck, 1);
    chk("t6_duty", bus.duty, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
